// File: rtl/serial_sub_pkg.sv
// ---------------------------------------------------------------------------
// serial_sub_pkg
//   Shared types for the bit-serial subtractor.
//   sub_state_t : controller state encoding (IDLE, SHIFT, DONE)
// ---------------------------------------------------------------------------
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sub_state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// ---------------------------------------------------------------------------
// full_subtractor
//   One-bit full subtractor cell: diff = a - b - bin.
//   a_i    in  1  minuend bit
//   b_i    in  1  subtrahend bit
//   bin_i  in  1  borrow in
//   diff_o out 1  difference bit
//   bout_o out 1  borrow out
// ---------------------------------------------------------------------------
module full_subtractor (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic diff_o,
    output logic bout_o
);

    assign diff_o = a_i ^ b_i ^ bin_i;
    assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial subtractor, LSB first: diff = a - b - borrow_in (mod 2^WIDTH),
//   one bit per clock through a single full_subtractor cell and a borrow FF.
//   clk_i      in  1      clock, rising edge
//   rst_ni     in  1      asynchronous active-low reset
//   start_i    in  1      request (accepted in IDLE, or on the edge leaving DONE)
//   a_i        in  WIDTH  minuend, captured on accept
//   b_i        in  WIDTH  subtrahend, captured on accept
//   borrow_i   in  1      borrow-in, captured on accept
//   busy_o     out 1      high while shifting (WIDTH cycles)
//   done_o     out 1      one-cycle result-valid pulse
//   diff_o     out WIDTH  result, held until the next operation completes
//   borrow_o   out 1      final borrow-out (unsigned underflow)
//   overflow_o out 1      signed overflow
//
//   state | meaning
//   IDLE  | waiting for start_i
//   SHIFT | one result bit per edge, WIDTH edges
//   DONE  | result just published, done_o high for one cycle
// ---------------------------------------------------------------------------
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             borrow_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o,
    output logic             overflow_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    sub_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             bf_q, bf_d;
    logic             a_sign_q, a_sign_d;
    logic             b_sign_q, b_sign_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;

    logic cell_d;
    logic cell_bout;

    full_subtractor u_cell (
        .a_i    (a_sr_q[0]),
        .b_i    (b_sr_q[0]),
        .bin_i  (bf_q),
        .diff_o (cell_d),
        .bout_o (cell_bout)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_d    = res_q;
        bf_d     = bf_q;
        a_sign_d = a_sign_q;
        b_sign_d = b_sign_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;

        case (state_q)
            // DONE shares the accept path with IDLE so back-to-back
            // operations run every WIDTH+1 cycles.
            IDLE, DONE: begin
                state_d = IDLE;
                if (start_i) begin
                    state_d  = SHIFT;
                    a_sr_d   = a_i;
                    b_sr_d   = b_i;
                    bf_d     = borrow_i;
                    cnt_d    = '0;
                    a_sign_d = a_i[WIDTH-1];
                    b_sign_d = b_i[WIDTH-1];
                end
            end
            SHIFT: begin
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                res_d  = {cell_d, res_q[WIDTH-1:1]};
                bf_d   = cell_bout;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d  = DONE;
                    cnt_d    = '0;
                    // Publish on the final bit so the held outputs change
                    // exactly once per operation.
                    diff_d   = {cell_d, res_q[WIDTH-1:1]};
                    borrow_d = cell_bout;
                    ovf_d    = (a_sign_q != b_sign_q) && (cell_d != a_sign_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_q    <= '0;
            bf_q     <= 1'b0;
            a_sign_q <= 1'b0;
            b_sign_q <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_q    <= res_d;
            bf_q     <= bf_d;
            a_sign_q <= a_sign_d;
            b_sign_q <= b_sign_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy_o     = (state_q == SHIFT);
    assign done_o     = (state_q == DONE);
    assign diff_o     = diff_q;
    assign borrow_o   = borrow_q;
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk_i = 1'b0;
    logic         rst_ni = 1'b0;
    logic         start_i = 1'b0;
    logic [W-1:0] a_i = '0;
    logic [W-1:0] b_i = '0;
    logic         borrow_i = 1'b0;
    logic         busy_o, done_o, borrow_o, overflow_o;
    logic [W-1:0] diff_o;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .start_i    (start_i),
        .a_i        (a_i),
        .b_i        (b_i),
        .borrow_i   (borrow_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .diff_o     (diff_o),
        .borrow_o   (borrow_o),
        .overflow_o (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Protocol monitor: busy/done exclusion and single-cycle done pulse.
    int   viol = 0;
    logic prev_done = 1'b0;
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (busy_o && done_o) viol++;
            if (done_o && prev_done) viol++;
        end
        prev_done = done_o && rst_ni;
    end

    // Reference: plain integer arithmetic on the operand values.
    function automatic void model(input int a, input int b, input int bin,
                                  output logic [W-1:0] d, output logic bo, output logic ov);
        int r, sa, sb, sr;
        r  = a - b - bin;
        d  = W'(r + 256);
        bo = (r < 0);
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        sr = sa - sb - bin;
        ov = (sr > 127) || (sr < -128);
    endfunction

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                          output logic [W-1:0] d, output logic bo, output logic ov,
                          output int lat, output int nbusy, output bit held);
        logic [W-1:0] pre_d;
        logic pre_b, pre_o;
        @(negedge clk_i);
        a_i = a; b_i = b; borrow_i = bin; start_i = 1'b1;
        pre_d = diff_o; pre_b = borrow_o; pre_o = overflow_o;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        a_i = W'($urandom); b_i = W'($urandom); borrow_i = 1'($urandom);
        lat = -1; nbusy = 0; held = 1'b1;
        for (int k = 1; k <= 3 * W; k++) begin
            if (busy_o) nbusy++;
            if (diff_o !== pre_d || borrow_o !== pre_b || overflow_o !== pre_o) held = 1'b0;
            @(posedge clk_i); #1;
            if (done_o) begin
                lat = k;
                break;
            end
        end
        d = diff_o; bo = borrow_o; ov = overflow_o;
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         bin;
        logic [W-1:0] exp_d;
        logic         exp_b;
        logic         exp_o;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [W-1:0] d, md;
        logic bo, ov, mbo, mov;
        int lat, nbusy, cnt;
        bit held;
        logic busy_k[20];
        logic done_k[20];

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0, 1'b0};
        vecs[1] = '{8'h10, 8'h20, 1'b0, 8'hF0, 1'b1, 1'b0};
        vecs[2] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[4] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1};
        vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[6] = '{8'h00, 8'h80, 1'b1, 8'h7F, 1'b1, 1'b0};
        vecs[7] = '{8'h7F, 8'h00, 1'b0, 8'h7F, 1'b0, 1'b0};

        #1;
        check("reset_diff", diff_o, 0);
        check("reset_flags", {busy_o, done_o, borrow_o, overflow_o}, 0);
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("idle_after_reset", {busy_o, done_o}, 0);

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, d, bo, ov, lat, nbusy, held);
            check($sformatf("vec%0d_diff", i), d, vecs[i].exp_d);
            check($sformatf("vec%0d_borrow", i), bo, vecs[i].exp_b);
            check($sformatf("vec%0d_ovf", i), ov, vecs[i].exp_o);
            check($sformatf("vec%0d_latency", i), lat, W);
            check($sformatf("vec%0d_busy_cycles", i), nbusy, W);
            check($sformatf("vec%0d_held", i), held, 1);
        end

        // Outputs hold after done.
        repeat (5) @(negedge clk_i);
        check("hold_after_done", {diff_o, borrow_o, overflow_o, done_o}, {8'h7F, 1'b0, 1'b0, 1'b0});

        // start held high: accepts at t0, t0+9, t0+18.
        @(negedge clk_i);
        a_i = 8'h05; b_i = 8'h03; borrow_i = 1'b0; start_i = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk_i); #1;
            busy_k[k] = busy_o;
            done_k[k] = done_o;
            if (k == 8) check("held_start_diff1", diff_o, 8'h02);
        end
        start_i = 1'b0;
        check("held_done_t8", done_k[8], 1);
        check("held_done_t17", done_k[17], 1);
        cnt = 0;
        for (int k = 0; k < 18; k++) cnt += int'(done_k[k]);
        check("held_done_count", cnt, 2);
        cnt = 0;
        for (int k = 0; k < 8; k++) cnt += int'(busy_k[k]);
        check("held_busy_first", cnt, 8);
        cnt = 0;
        for (int k = 9; k < 17; k++) cnt += int'(busy_k[k]);
        check("held_busy_second", cnt, 8);
        check("held_busy_gaps", {busy_k[8], busy_k[17]}, 0);
        lat = -1;
        for (int k = 0; k < 3 * W; k++) begin
            @(posedge clk_i); #1;
            if (done_o) begin lat = k; break; end
        end
        check("held_third_done_seen", lat >= 0, 1);
        check("held_start_diff3", diff_o, 8'h02);

        // Reset mid-SHIFT.
        run_op(8'h10, 8'h20, 1'b0, d, bo, ov, lat, nbusy, held);
        @(negedge clk_i);
        a_i = 8'h33; b_i = 8'h11; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1 rst_ni = 1'b0;
        #1;
        check("midrst_diff", diff_o, 0);
        check("midrst_flags", {busy_o, done_o, borrow_o, overflow_o}, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk_i);
            cnt += int'(done_o) + int'(busy_o);
        end
        check("midrst_no_done", cnt, 0);
        run_op(8'hFF, 8'h01, 1'b0, d, bo, ov, lat, nbusy, held);
        check("post_rst_diff", d, 8'hFE);
        check("post_rst_flags", {bo, ov}, 0);
        check("post_rst_latency", lat, W);

        // Random operands against the integer model.
        for (int n = 0; n < 1000; n++) begin
            logic [W-1:0] ra, rb;
            logic rbin;
            ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
            model(int'(ra), int'(rb), int'(rbin), md, mbo, mov);
            run_op(ra, rb, rbin, d, bo, ov, lat, nbusy, held);
            check($sformatf("rnd%0d_%0h_%0h_%0d", n, ra, rb, rbin), {d, bo, ov}, {md, mbo, mov});
            if (lat != W) check($sformatf("rnd%0d_latency", n), lat, W);
        end

        check("protocol_violations", viol, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
